tx_rr_scheduler: RTL and testbench



---
 rtl/tx_rr_scheduler_if.sv | 24 ++
 rtl/tx_rr_scheduler.sv | 151 +++++++++++++++
 tb/tb_tx_rr_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_rr_scheduler_if.sv
// Bundle between the byte producers, the round-robin scheduler and the serial transmitter.
// Handshake: req is a level held until the matching done pulse; tx_send stays high until tx_busy is seen high, and a frame ends when tx_busy falls.
`timescale 1ns/1ps
interface tx_rr_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   grant;
    logic               tx_send;
    logic [7:0]         tx_din;
    logic               tx_busy;

    modport master (
        input  req, req_data, tx_busy,
        output done, grant, tx_send, tx_din
    );

    modport slave (
        output req, req_data, tx_busy,
        input  done, grant, tx_send, tx_din
    );
endinterface

// File: rtl/tx_rr_scheduler.sv
// Round-robin arbiter that shares one serial transmitter among N_REQ byte producers.
// Each grant launches one frame, waits for it to finish, pulses done, then re-arbitrates.
`timescale 1ns/1ps
module tx_rr_scheduler #(
    parameter int N_REQ          = 4,
    parameter int LAUNCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    tx_rr_scheduler_if.master  bus,
    output logic               err,
    input  logic               err_clr,
    output logic [1:0]         dbg_state
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_XMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               tx_send_q, tx_send_d;
    logic [7:0]         tx_din_q, tx_din_d;
    logic               err_q, err_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic [7:0]         win_byte;
    logic [PTR_W:0]     cand_sum;

    // Search starts one past the last served requester and wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
            end
            if (!win_found && bus.req[cand_sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_oh   = '0;
        win_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                win_oh[i] = 1'b1;
                win_byte  = bus.req_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        done_d    = '0;
        tx_send_d = 1'b0;
        tx_din_d  = tx_din_q;
        err_d     = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d   = win_oh;
                    owner_d   = win_idx;
                    tx_din_d  = win_byte;
                    tx_send_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.tx_busy) begin
                    state_d = S_XMIT;
                end else if (cnt_q == CNT_W'(LAUNCH_TIMEOUT - 1)) begin
                    // A timeout outranks a simultaneous err_clr.
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    tx_send_d = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            S_XMIT: begin
                if (!bus.tx_busy) begin
                    done_d  = grant_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = owner_q;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_W'(N_REQ - 1);
            owner_q   <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            tx_send_q <= 1'b0;
            tx_din_q  <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            tx_send_q <= tx_send_d;
            tx_din_q  <= tx_din_d;
            err_q     <= err_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.tx_send = tx_send_q;
    assign bus.tx_din  = tx_din_q;
    assign err         = err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_tx_rr_scheduler.sv
// Bench for tx_rr_scheduler: a behavioural serial transmitter plus directed and randomized scenarios.
`timescale 1ns/1ps
module tb_tx_rr_scheduler;
    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err;
    logic       err_clr = 1'b0;
    logic [1:0] dbg_state;
    int         cyc = 0;

    tx_rr_scheduler_if #(.N_REQ(N)) bus ();

    tx_rr_scheduler #(.N_REQ(N), .LAUNCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    // Transmitter model state and observations.
    bit          tx_dead = 1'b0;
    int          x_phase = 0;
    int          x_bit = 0;
    logic [7:0]  x_byte;
    logic [10:0] x_frame;
    logic [10:0] x_ser;
    logic [10:0] last_ser = '0;
    int          last_fall = -1;
    int          min_gap = 1000;
    int          din_viol = 0;
    int          ack_stuck = 0;
    logic [7:0]  sent_q[$];
    logic [7:0]  exp_q[$];

    // Frame: start 0, data LSB first, odd parity, stop 1; busy is high while bits shift out.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.tx_busy = 1'b0;
                x_phase = 0;
            end else begin
                case (x_phase)
                    0: if (bus.tx_send && !tx_dead) begin
                        x_byte  = bus.tx_din;
                        x_frame = {1'b1, ~^bus.tx_din, bus.tx_din, 1'b0};
                        x_bit   = 0;
                        bus.tx_busy = 1'b1;
                        x_phase = 1;
                        if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
                    end
                    1: begin
                        if (bus.tx_din !== x_byte) din_viol++;
                        x_ser[x_bit] = x_frame[x_bit];
                        x_bit++;
                        if (x_bit == 11) begin
                            bus.tx_busy = 1'b0;
                            x_phase = 2;
                            sent_q.push_back(x_byte);
                            last_ser = x_ser;
                            last_fall = cyc;
                        end
                    end
                    default: if (!bus.tx_send) x_phase = 0; else ack_stuck++;
                endcase
            end
        end
    end

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        err_clr = 1'b0;
        tx_dead = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(output int idx, output bit ok, input int budget);
        ok = 1'b0;
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (|bus.done) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (bus.done[i]) idx = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '1;
        bus.req_data = $urandom;
        repeat (2) @(negedge clk);
        checks++; if (bus.grant !== '0) $display("FAIL reset_grant got %b want 0000", bus.grant); else passes++;
        checks++; if (bus.done !== '0) $display("FAIL reset_done got %b want 0000", bus.done); else passes++;
        checks++; if (bus.tx_send !== 1'b0) $display("FAIL reset_send got %b want 0", bus.tx_send); else passes++;
        checks++; if (bus.tx_din !== 8'h00) $display("FAIL reset_din got %h want 00", bus.tx_din); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passes++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else passes++;
        bus.req = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int idx;
        bit ok;
        do_reset();
        sent_q.delete();
        din_viol = 0;
        bus.req_data = $urandom;
        bus.req_data[15:8] = 8'hA5;
        bus.req = 4'b0010;
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0010) $display("FAIL single_grant got %b want 0010", bus.grant); else passes++;
        checks++; if (bus.tx_send !== 1'b1) $display("FAIL single_send got %b want 1", bus.tx_send); else passes++;
        checks++; if (bus.tx_din !== 8'hA5) $display("FAIL single_din got %h want a5", bus.tx_din); else passes++;
        wait_done(idx, ok, 60);
        checks++; if (!ok || idx != 1) $display("FAIL single_done_idx got %0d want 1", idx); else passes++;
        checks++; if (bus.done !== 4'b0010) $display("FAIL single_done_vec got %b want 0010", bus.done); else passes++;
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.done !== '0) $display("FAIL single_done_once got %b want 0000", bus.done); else passes++;
        checks++; if (bus.grant !== '0) $display("FAIL single_grant_idle got %b want 0000", bus.grant); else passes++;
        checks++; if (sent_q.size() != 1 || sent_q[0] !== 8'hA5) $display("FAIL single_sent got %0d frames want one a5", sent_q.size()); else passes++;
        checks++; if (last_ser !== {1'b1, 1'b1, 8'hA5, 1'b0}) $display("FAIL single_serial got %b want %b", last_ser, {1'b1, 1'b1, 8'hA5, 1'b0}); else passes++;
        checks++; if (din_viol != 0) $display("FAIL single_din_stable got %0d changes want 0", din_viol); else passes++;
    endtask

    task automatic test_all_four();
        int idx;
        bit ok;
        logic [7:0] exp_b[4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        sent_q.delete();
        din_viol = 0;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(idx, ok, 60);
            checks++; if (!ok || idx != k) $display("FAIL all_four_order got %0d want %0d", idx, k); else passes++;
            if (ok) bus.req[idx] = 1'b0;
        end
        checks++; if (sent_q.size() != 4) $display("FAIL all_four_count got %0d want 4", sent_q.size()); else passes++;
        for (int k = 0; k < sent_q.size() && k < 4; k++) begin
            checks++; if (sent_q[k] !== exp_b[k]) $display("FAIL all_four_byte got %h want %h", sent_q[k], exp_b[k]); else passes++;
        end
        checks++; if (din_viol != 0) $display("FAIL all_four_din_stable got %0d changes want 0", din_viol); else passes++;
    endtask

    task automatic test_fairness();
        int idx;
        bit ok;
        int got[4];
        do_reset();
        bus.req_data = $urandom;
        bus.req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_done(idx, ok, 60);
            got[k] = idx;
            checks++; if (!ok || idx != ((k % 2) * 2)) $display("FAIL fair_order got %0d want %0d", idx, (k % 2) * 2); else passes++;
            if (k > 0) begin
                checks++; if (got[k] == 0 && got[k-1] == 0) $display("FAIL fair_no_repeat got %0d twice want alternation", got[k]); else passes++;
            end
        end
        bus.req = '0;
    endtask

    task automatic test_back_to_back();
        int idx;
        bit ok;
        do_reset();
        min_gap = 1000;
        last_fall = -1;
        ack_stuck = 0;
        bus.req_data = $urandom;
        bus.req = 4'b1001;
        for (int k = 0; k < 4; k++) wait_done(idx, ok, 60);
        checks++; if (min_gap < 2 || min_gap == 1000) $display("FAIL b2b_gap got %0d want >=2", min_gap); else passes++;
        checks++; if (ack_stuck != 0) $display("FAIL b2b_ack_stuck got %0d want 0", ack_stuck); else passes++;
        bus.req = '0;
    endtask

    task automatic test_timeout();
        int send_cnt;
        bit saw_done;
        bit saw_err;
        bit set_win;
        do_reset();
        tx_dead = 1'b1;
        send_cnt = 0;
        saw_done = 1'b0;
        saw_err = 1'b0;
        bus.req_data = $urandom;
        bus.req = 4'b1000;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|bus.done) saw_done = 1'b1;
            if (err) begin
                saw_err = 1'b1;
                break;
            end
            if (bus.tx_send) send_cnt++;
        end
        checks++; if (!saw_err) $display("FAIL timeout_err got 0 want 1"); else passes++;
        checks++; if (send_cnt != TO) $display("FAIL timeout_send_len got %0d want %0d", send_cnt, TO); else passes++;
        checks++; if (bus.grant !== '0) $display("FAIL timeout_grant got %b want 0000", bus.grant); else passes++;
        checks++; if (bus.tx_send !== 1'b0) $display("FAIL timeout_send_low got %b want 0", bus.tx_send); else passes++;
        checks++; if (saw_done) $display("FAIL timeout_no_done got 1 want 0"); else passes++;
        err_clr = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b0) $display("FAIL timeout_clr got %b want 0", err); else passes++;
        set_win = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (err) begin
                set_win = 1'b1;
                break;
            end
        end
        checks++; if (!set_win) $display("FAIL timeout_set_wins got 0 want 1"); else passes++;
        err_clr = 1'b0;
        bus.req = '0;
        tx_dead = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        bus.req_data = $urandom;
        bus.req_data[15:8] = 8'h5A;
        bus.req = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) $display("FAIL areset_reach_xmit got busy 0 want 1"); else passes++;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== '0) $display("FAIL areset_grant got %b want 0000", bus.grant); else passes++;
        checks++; if (bus.tx_din !== 8'h00) $display("FAIL areset_din got %h want 00", bus.tx_din); else passes++;
        checks++; if (bus.tx_send !== 1'b0) $display("FAIL areset_send got %b want 0", bus.tx_send); else passes++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL areset_state got %0d want 0", dbg_state); else passes++;
        @(negedge clk);
        bus.req = 4'b0011;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 4'b0001) $display("FAIL areset_first_grant got %b want 0001", bus.grant); else passes++;
        bus.req = '0;
    endtask

    task automatic test_random();
        int ptr_m;
        int owner_m;
        int w;
        bit drained;
        logic [N-1:0] gprev;
        do_reset();
        sent_q.delete();
        exp_q.delete();
        din_viol = 0;
        ptr_m = N - 1;
        owner_m = -1;
        gprev = '0;
        drained = 1'b0;
        bus.req_data = $urandom;
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            if (bus.grant != '0 && gprev == '0) begin
                w = pick(bus.req, ptr_m);
                checks++; if (w < 0 || bus.grant !== (N'(1) << w)) $display("FAIL rnd_grant got %b want requester %0d", bus.grant, w); else passes++;
                owner_m = w;
                if (w >= 0) begin
                    exp_q.push_back(bus.req_data[8*w +: 8]);
                    bus.req_data[8*w +: 8] = 8'($urandom);
                end
            end
            gprev = bus.grant;
            if (bus.done != '0) begin
                checks++; if (owner_m < 0 || bus.done !== (N'(1) << owner_m)) $display("FAIL rnd_done got %b want requester %0d", bus.done, owner_m); else passes++;
                if (owner_m >= 0) begin
                    ptr_m = owner_m;
                    if (c >= 500 || $urandom_range(3) != 0) bus.req[owner_m] = 1'b0;
                end
                owner_m = -1;
            end
            if (c < 500) begin
                for (int i = 0; i < N; i++) begin
                    if (!bus.req[i] && $urandom_range(7) == 0) begin
                        bus.req_data[8*i +: 8] = 8'($urandom);
                        bus.req[i] = 1'b1;
                    end
                end
            end else if (bus.req == '0 && bus.grant == '0) begin
                drained = 1'b1;
                break;
            end
        end
        checks++; if (!drained) $display("FAIL rnd_drain got req %b grant %b want idle", bus.req, bus.grant); else passes++;
        checks++; if (exp_q.size() < 5) $display("FAIL rnd_activity got %0d grants want >=5", exp_q.size()); else passes++;
        checks++; if (sent_q.size() != exp_q.size()) $display("FAIL rnd_frame_count got %0d want %0d", sent_q.size(), exp_q.size()); else passes++;
        for (int k = 0; k < sent_q.size() && k < exp_q.size(); k++) begin
            checks++; if (sent_q[k] !== exp_q[k]) $display("FAIL rnd_byte got %h want %h at frame %0d", sent_q[k], exp_q[k], k); else passes++;
        end
        checks++; if (din_viol != 0) $display("FAIL rnd_din_stable got %0d changes want 0", din_viol); else passes++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
